// File: rtl/delay_line_ctrl.sv
// Address sequencer for an external simple-dual-port RAM forming a programmable delay line.
// Samples are written at wp and read back len samples later; output is held off until primed.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 25,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    output logic                  cfg_ready,
    output logic                  cfg_err,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  primed,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_rden,
    output logic [ADDR_WIDTH-1:0] ram_rdaddr,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic                  vld_p1_q, vld_p1_d;
    logic                  err_q, err_d;

    logic                  cfg_ok;
    logic                  cfg_bad;
    logic                  accept;
    logic                  fill_full;
    logic [ADDR_WIDTH-1:0] fill_inc;

    // Input handshake: a pending config always wins over a sample
    always_comb begin
        cfg_ok    = cfg_valid && (cfg_len != '0);
        cfg_bad   = cfg_valid && (cfg_len == '0);
        s_ready   = (state_q != IDLE) && !cfg_valid;
        accept    = s_valid && s_ready;
        fill_full = (fill_q == len_q);
        fill_inc  = fill_q + ADDR_WIDTH'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_ok) state_d = FILL;
            end
            FILL: begin
                if (cfg_ok) begin
                    state_d = FILL;
                end else if (accept && (fill_inc == len_q)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cfg_ok) state_d = FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wp_d     = wp_q;
        len_d    = len_q;
        fill_d   = fill_q;
        vld_p1_d = 1'b0;
        err_d    = cfg_bad;
        if (cfg_ok) begin
            len_d  = cfg_len;
            fill_d = '0;
        end else if (accept) begin
            wp_d     = wp_q + ADDR_WIDTH'(1);
            fill_d   = fill_full ? fill_q : fill_inc;
            vld_p1_d = fill_full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            len_q    <= '0;
            fill_q   <= '0;
            vld_p1_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
            vld_p1_q <= vld_p1_d;
            err_q    <= err_d;
        end
    end

    // p0 -> p1: the RAM read issued with an accept returns one cycle later
    always_comb begin
        cfg_ready  = 1'b1;
        cfg_err    = err_q;
        primed     = (state_q == RUN);
        ram_we     = accept;
        ram_wraddr = wp_q;
        ram_di     = s_data;
        ram_rden   = accept;
        ram_rdaddr = wp_q - len_q;
        m_valid    = vld_p1_q;
        m_data     = ram_do;
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
Controller that sequences an external simple-dual-port block RAM, one write port and one read port, both on clk. Together they form a run-time-programmable delay line. The block accepts a sample stream with a valid/ready handshake and generates the RAM write and read addresses. It suppresses output until the line is primed with the configured number of samples, then emits each sample exactly cfg_len accepted samples later. It sits between a sample source and the RAM; the RAM itself is instantiated alongside it.

Parameters:
DATA_WIDTH, 25, sample width in bits.
ADDR_WIDTH, 9, RAM address width; maximum delay is 2**ADDR_WIDTH-1 samples.

Ports:
clk  input  1  clock; the RAM is clocked by the same clk.
rst_n  input  1  synchronous active-low reset.
cfg_valid  input  1  new delay length offered.
cfg_len  input  ADDR_WIDTH  requested delay in samples; legal range 1..2**ADDR_WIDTH-1.
cfg_ready  output  1  controller can take a configuration.
cfg_err  output  1  one-cycle pulse when an offered cfg_len is illegal (0).
s_valid  input  1  input sample valid.
s_data  input  DATA_WIDTH  input sample.
s_ready  output  1  sample accepted when s_valid && s_ready.
m_valid  output  1  delayed sample valid; no backpressure.
m_data  output  DATA_WIDTH  delayed sample.
primed  output  1  line holds at least len samples since the last (re)configuration.
ram_we  output  1  RAM write enable.
ram_wraddr  output  ADDR_WIDTH  RAM write address.
ram_di  output  DATA_WIDTH  RAM write data.
ram_rden  output  1  RAM read enable.
ram_rdaddr  output  ADDR_WIDTH  RAM read address.
ram_do  input  DATA_WIDTH  RAM read data, valid 1 cycle after ram_rden.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE, wp=0, len=0, fill=0.
  - m_valid=0, cfg_err=0, primed=0.
  - RAM contents are not cleared.
- States: IDLE (unconfigured), FILL (priming), RUN (streaming).
- cfg_ready=1 in all states; cfg_valid && cfg_ready is a config handshake.
- s_ready = (state != IDLE) && !cfg_valid. A config request stalls input for that cycle and has priority over a sample.
- Config handshake, legal cfg_len:
  - len <= cfg_len, fill <= 0, next state FILL.
  - wp is unchanged.
  - Any m_valid due next cycle still fires, because that read was issued earlier.
- Config handshake, cfg_len == 0:
  - cfg_err pulses for 1 cycle.
  - len, fill and state are unchanged; from IDLE the state stays IDLE.
- Sample accept at cycle t:
  - Write side (combinational in cycle t): ram_we=1, ram_wraddr=wp, ram_di=s_data.
  - Read side (combinational in cycle t): ram_rden=1, ram_rdaddr=(wp-len) mod 2**ADDR_WIDTH.
  - Registered updates: wp <= wp+1 (wraps at 2**ADDR_WIDTH); fill <= min(fill+1, len).
- With no accept: ram_we=0 and ram_rden=0.
- Read/write collision: rdaddr never equals wraddr, since 1 <= len <= 2**ADDR_WIDTH-1, so the RAM write mode is irrelevant.
- Output:
  - m_valid at t+1 is 1 iff there was an accept at t with fill==len at t (pre-increment).
  - m_data = ram_do, combinational passthrough.
  - Latency from accept to output is 1 cycle. The output equals the sample accepted exactly len accepts earlier.
- Transitions:
  - FILL -> RUN on the accept that makes fill reach len.
  - primed = (state == RUN).
  - From RUN, only a config handshake or reset leaves.
- Accepts and outputs are always 1:1 once primed; gaps in s_valid produce identical gaps in m_valid.
- Reset mid-stream: any output scheduled for the next cycle is dropped (m_valid=0).
- fill and len arithmetic are ADDR_WIDTH bits, unsigned; fill saturates and never wraps.

Test Plan:
1. Reset, cfg_len=4, continuous samples 0..9:
   - First m_valid is the cycle after sample 4 is accepted, with m_data=0.
   - Subsequent m_data values are 1,2,3,4,5.
   - primed rises with the sample-4 accept.
2. Same as 1 with s_valid toggling 1,0,1,0:
   - m_valid follows accepts with 1-cycle lag.
   - Data order and values are identical to scenario 1.
3. cfg_len=0 offered while in RUN with len=4:
   - cfg_err is a 1-cycle pulse.
   - Output stream continues unchanged; primed stays 1.
4. Mid-stream reconfig 4->2 after sample 9 (samples continue from 10):
   - s_ready=0 on the cfg cycle, and primed drops.
   - The sample-9 output (m_data=5) still appears.
   - No m_valid for samples 10 and 11.
   - Accepting sample 12 gives m_data=10, then 11, 12 and so on.
5. cfg_len=511 with 1100 continuous samples:
   - First output (data 0) follows the sample-511 accept.
   - Wraparound is correct; the output for sample 1099 is 588.
   - ram_rdaddr never equals ram_wraddr.
6. Reset asserted during RUN:
   - m_valid=0, s_ready=0 and primed=0 the next cycle.
   - After reconfiguring to len=3, the first output appears after 4 accepts and carries the first post-reset sample.
